// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_scan_pkg                                              |
// | Brief    : Shared types, constants and hex->7-segment table for the  |
// |            segment scan controller.                                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package seg_scan_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Active-high gfedcba, seg[0] = a
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_to_seg7                                               |
// | Brief    : Combinational nibble to active-high gfedcba decoder.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex7(nibble);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_scan_ctrl                                             |
// | Brief    : Time-multiplexed 7-segment scan controller with dead-time |
// |            blanking, frame-aligned double buffering and selectable   |
// |            output polarity. Define SEG_SCAN_LZB_EN for leading-zero  |
// |            blanking.                                                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NDIG      = 2,
    parameter int DWELL_CYC = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] digits_in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              cathod,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              dp,
    output logic              pending,
    output logic              frame_start
);

    localparam int c_IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int c_MAX_C  = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int c_CNT_W  = $clog2(c_MAX_C + 1);
    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NDIG - 1);

    if (NDIG < 1 || DWELL_CYC < 1 || BLANK_CYC < 1) begin : g_param_err
        $error("seg_scan_ctrl: NDIG, DWELL_CYC and BLANK_CYC must all be >= 1");
    end

    scan_state_t          r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx,   w_idx_nxt;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [6:0]           r_seg,   w_seg_nxt;
    logic [NDIG-1:0]      r_an,    w_an_nxt;
    logic                 r_dp,    w_dp_nxt;
    logic                 w_boundary;

    logic [4*NDIG-1:0]    r_shadow;
    logic [NDIG-1:0]      r_shadow_dp;
    logic [4*NDIG-1:0]    r_active;
    logic [NDIG-1:0]      r_active_dp;
    logic                 r_pending;
    logic                 r_frame_start;

    logic [3:0]           w_nib;
    logic [6:0]           w_hex;
    logic [6:0]           w_seg_sel;
    logic [NDIG-1:0]      w_an_sel;

    assign w_nib    = r_active[{r_idx, 2'b00} +: 4];
    assign w_an_sel = NDIG'(1) << r_idx;

    hex_to_seg7 u_hex (
        .nibble (w_nib),
        .seg    (w_hex)
    );

`ifdef SEG_SCAN_LZB_EN
    // w_lead_zero[i]: digit i and every digit above it are zero
    logic [NDIG-1:0] w_lead_zero;
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_lead_zero
        assign w_lead_zero[gi] = ~|r_active[4*NDIG-1:4*gi];
    end
    assign w_seg_sel = ((r_idx != '0) && w_lead_zero[r_idx]) ? SEG_OFF : w_hex;
`else
    assign w_seg_sel = w_hex;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_seg_nxt   = r_seg;
        w_an_nxt    = r_an;
        w_dp_nxt    = r_dp;
        w_boundary  = 1'b0;
        case (r_state)
            BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_state_nxt = SHOW;
                    w_cnt_nxt   = '0;
                    w_an_nxt    = w_an_sel;
                    w_seg_nxt   = w_seg_sel;
                    w_dp_nxt    = r_active_dp[r_idx];
                end
            end
            SHOW: begin
                if (r_cnt == c_DWELL_LAST) begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
                    w_an_nxt    = '0;
                    w_seg_nxt   = SEG_OFF;
                    w_dp_nxt    = 1'b0;
                    w_boundary  = (r_idx == c_IDX_LAST);
                end
            end
            default: begin
                w_state_nxt = BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BLANK;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_seg         <= SEG_OFF;
            r_an          <= '0;
            r_dp          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_seg         <= w_seg_nxt;
            r_an          <= w_an_nxt;
            r_dp          <= w_dp_nxt;
            r_frame_start <= w_boundary;
        end
    end

    // Active only ever changes on a frame boundary, so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_active    <= '0;
            r_active_dp <= '0;
            r_pending   <= 1'b0;
        end else if (load && w_boundary) begin
            r_shadow    <= digits_in;
            r_shadow_dp <= dp_in;
            r_active    <= digits_in;
            r_active_dp <= dp_in;
            r_pending   <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_active    <= r_shadow;
                r_active_dp <= r_shadow_dp;
                r_pending   <= 1'b0;
            end
            if (load) begin
                r_shadow    <= digits_in;
                r_shadow_dp <= dp_in;
                r_pending   <= 1'b1;
            end
        end
    end

    assign seg         = r_seg ^ {7{~cathod}};
    assign an          = r_an  ^ {NDIG{~cathod}};
    assign dp          = r_dp  ^ ~cathod;
    assign pending     = r_pending;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seg_scan_ctrl                                          |
// | Brief    : Directed self-checking bench for seg_scan_ctrl            |
// |            (NDIG=2, DWELL_CYC=4, BLANK_CYC=2).                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] digits_in;
    logic [1:0] dp_in;
    logic       cathod;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;
    logic       pending;
    logic       frame_start;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    seg_scan_ctrl #(
        .NDIG      (2),
        .DWELL_CYC (4),
        .BLANK_CYC (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .cathod      (cathod),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .pending     (pending),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int e);
        while (cyc < e) tick();
    endtask

    task automatic do_load(input logic [7:0] d, input logic [1:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    // Digit 1 value zero is blanked with leading-zero blanking
`ifdef SEG_SCAN_LZB_EN
    localparam logic [6:0] c_D1_ZERO = 7'h7F;
`else
    localparam logic [6:0] c_D1_ZERO = 7'h40;
`endif

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        digits_in = 8'h00;
        dp_in     = 2'b00;
        cathod    = 1'b0;
        repeat (3) tick();
        check("rst_seg",   16'(seg),         16'h7F);
        check("rst_an",    16'(an),          16'h3);
        check("rst_dp",    16'(dp),          16'h1);
        check("rst_pend",  16'(pending),     16'h0);
        check("rst_fs",    16'(frame_start), 16'h0);

        rst = 1'b0;
        cyc = 0;
        go_to(1);
        check("blank0_an", 16'(an), 16'h3);
        go_to(2);
        check("d0_an",     16'(an),  16'h2);
        check("d0_seg",    16'(seg), 16'h40);
        check("d0_dp",     16'(dp),  16'h1);
        go_to(5);
        check("d0_hold",   16'(an),  16'h2);
        go_to(6);
        check("blank1_an", 16'(an),  16'h3);
        go_to(8);
        check("d1_an",     16'(an),  16'h1);
        check("d1_seg",    16'(seg), 16'(c_D1_ZERO));

        // Mid-frame load 42
        go_to(9);
        do_load(8'h42, 2'b01);
        check("ld_pend",   16'(pending), 16'h1);
        check("ld_nodist", 16'(seg),     16'(c_D1_ZERO));
        go_to(12);
        check("bnd_fs",    16'(frame_start), 16'h1);
        check("bnd_pend",  16'(pending),     16'h0);
        check("bnd_an",    16'(an),          16'h3);
        go_to(13);
        check("fs_pulse",  16'(frame_start), 16'h0);
        go_to(14);
        check("42_d0_seg", 16'(seg), 16'h24);
        check("42_d0_dp",  16'(dp),  16'h0);
        go_to(20);
        check("42_d1_an",  16'(an),  16'h1);
        check("42_d1_seg", 16'(seg), 16'h19);
        check("42_d1_dp",  16'(dp),  16'h1);

        // Two loads in one frame: last wins
        go_to(21);
        do_load(8'h11, 2'b00);
        do_load(8'h99, 2'b00);
        go_to(24);
        check("99_fs",     16'(frame_start), 16'h1);
        go_to(26);
        check("99_d0_seg", 16'(seg), 16'h10);
        go_to(32);
        check("99_d1_seg", 16'(seg), 16'h10);

        // Load landing exactly on the boundary edge
        go_to(35);
        do_load(8'h37, 2'b00);
        check("37_fs",     16'(frame_start), 16'h1);
        check("37_pend",   16'(pending),     16'h0);
        go_to(38);
        check("37_d0_an",  16'(an),  16'h2);
        check("37_d0_seg", 16'(seg), 16'h78);
        go_to(44);
        check("37_d1_seg", 16'(seg), 16'h30);

        // Polarity flip while digit 0 shows 0
        go_to(45);
        do_load(8'h00, 2'b00);
        go_to(50);
        check("00_d0_seg", 16'(seg), 16'h40);
        cathod = 1'b1;
        #1;
        check("cc_seg",    16'(seg), 16'h3F);
        check("cc_an",     16'(an),  16'h1);
        check("cc_dp",     16'(dp),  16'h0);
        cathod = 1'b0;
        #1;

        // Leading digit zero
        go_to(51);
        do_load(8'h05, 2'b00);
        go_to(62);
        check("05_d0_seg", 16'(seg), 16'h12);
        go_to(68);
        check("05_d1_an",  16'(an),  16'h1);
        check("05_d1_seg", 16'(seg), 16'(c_D1_ZERO));

        // Reset mid-scan drops a pending load
        go_to(69);
        do_load(8'h88, 2'b11);
        check("pre_rst_pend", 16'(pending), 16'h1);
        rst = 1'b1;
        tick();
        check("mrst_pend", 16'(pending), 16'h0);
        check("mrst_an",   16'(an),      16'h3);
        check("mrst_seg",  16'(seg),     16'h7F);
        rst = 1'b0;
        cyc = 0;
        go_to(1);
        check("mrst_blank", 16'(an), 16'h3);
        go_to(2);
        check("mrst_d0_an",  16'(an),  16'h2);
        check("mrst_d0_seg", 16'(seg), 16'h40);
        check("mrst_d0_dp",  16'(dp),  16'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
